// File: rtl/buffer_controller_if.sv
// Control and status bundle between buffer_controller, the AHB slave, the USB RX/TX
// packet logic and the endpoint data buffer.
interface buffer_controller_if;
  logic [6:0] buffer_occupancy;
  logic       rx_packet_start;
  logic       rx_byte_valid;
  logic       rx_packet_done;
  logic       rx_packet_error;
  logic       ahb_read_req;
  logic       ahb_write_req;
  logic [1:0] ahb_size;
  logic       tx_send_req;
  logic       tx_byte_req;
  logic       tx_packet_done;
  logic       flush_req;
  logic       store_rx_packet_data;
  logic       get_rx_data;
  logic       store_tx_data;
  logic       get_tx_packet_data;
  logic [1:0] data_size;
  logic       clear;
  logic       buffer_reserved;
  logic       rx_data_ready;
  logic       tx_busy;
  logic       ahb_stall;
  logic       ahb_error;
  logic       rx_nak;
  logic       rx_error;

  modport slave (
    input  buffer_occupancy, rx_packet_start, rx_byte_valid, rx_packet_done,
           rx_packet_error, ahb_read_req, ahb_write_req, ahb_size, tx_send_req,
           tx_byte_req, tx_packet_done, flush_req,
    output store_rx_packet_data, get_rx_data, store_tx_data, get_tx_packet_data,
           data_size, clear, buffer_reserved, rx_data_ready, tx_busy, ahb_stall,
           ahb_error, rx_nak, rx_error
  );

  modport master (
    output buffer_occupancy, rx_packet_start, rx_byte_valid, rx_packet_done,
           rx_packet_error, ahb_read_req, ahb_write_req, ahb_size, tx_send_req,
           tx_byte_req, tx_packet_done, flush_req,
    input  store_rx_packet_data, get_rx_data, store_tx_data, get_tx_packet_data,
           data_size, clear, buffer_reserved, rx_data_ready, tx_busy, ahb_stall,
           ahb_error, rx_nak, rx_error
  );
endinterface

// File: rtl/buffer_controller.sv
// Ownership/sequencing controller for the 64-byte endpoint buffer (RX writer, AHB, TX reader).
// Optional RX inter-byte watchdog: define BUFFER_CONTROLLER_RX_TIMEOUT_EN.
module buffer_controller #(
  parameter int BUFFER_DEPTH   = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic             clk,
  input logic             n_rst,
  buffer_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RX_ACTIVE, RX_READY, TX_FILL, TX_SEND} state_t;

  localparam logic [6:0] DEPTH = 7'(BUFFER_DEPTH);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit watchdog");
  end

  state_t     state, next_state;
  logic       clear_q, ahb_error_q, rx_nak_q, rx_error_q;
  logic       clear_d, ahb_error_d, rx_nak_d, rx_error_d;
  logic       store_rx, get_rx, store_tx, get_tx, stall;
  logic       rx_timeout;
  logic [6:0] occ, n_bytes, rx_count_after;

  assign occ            = bus.buffer_occupancy;
  assign n_bytes        = 7'(bus.ahb_size) + 7'd1;
  assign rx_count_after = occ + {6'd0, store_rx};

`ifdef BUFFER_CONTROLLER_RX_TIMEOUT_EN
  logic [7:0] rx_timer;

  // Held at zero outside RX_ACTIVE, so it reads 0 on the first RX_ACTIVE cycle.
  always_ff @(posedge clk) begin
    if (!n_rst || state != RX_ACTIVE || bus.rx_byte_valid) rx_timer <= 8'd0;
    else                                                   rx_timer <= rx_timer + 8'd1;
  end

  assign rx_timeout = (state == RX_ACTIVE) && !bus.rx_byte_valid &&
                      (rx_timer == 8'(TIMEOUT_CYCLES - 1));
`else
  assign rx_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    next_state  = state;
    store_rx    = 1'b0;
    get_rx      = 1'b0;
    store_tx    = 1'b0;
    get_tx      = 1'b0;
    stall       = 1'b0;
    clear_d     = 1'b0;
    ahb_error_d = 1'b0;
    rx_nak_d    = 1'b0;
    rx_error_d  = 1'b0;

    if (bus.flush_req) begin
      clear_d    = 1'b1;
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.rx_packet_start) begin
            next_state = RX_ACTIVE;
            stall      = bus.ahb_write_req;
          end else if (bus.ahb_write_req) begin
            store_tx   = 1'b1;
            next_state = TX_FILL;
          end
          if (bus.ahb_read_req) ahb_error_d = 1'b1;
        end
        RX_ACTIVE: begin
          stall = bus.ahb_read_req | bus.ahb_write_req;
          if (bus.rx_packet_error || rx_timeout) begin
            clear_d    = 1'b1;
            rx_error_d = 1'b1;
            next_state = IDLE;
          end else if (bus.rx_byte_valid && occ >= DEPTH) begin
            clear_d    = 1'b1;
            rx_error_d = 1'b1;
            next_state = IDLE;
          end else begin
            store_rx = bus.rx_byte_valid;
            // A byte landing with the done pulse counts toward the final occupancy.
            if (bus.rx_packet_done)
              next_state = (rx_count_after != 7'd0) ? RX_READY : IDLE;
          end
        end
        RX_READY: begin
          if (bus.ahb_read_req) begin
            if (occ >= n_bytes) begin
              get_rx = 1'b1;
              if (occ == n_bytes) next_state = IDLE;
            end else begin
              ahb_error_d = 1'b1;
            end
          end
          if (bus.ahb_write_req)   ahb_error_d = 1'b1;
          if (bus.rx_packet_start) rx_nak_d    = 1'b1;
        end
        TX_FILL: begin
          if (bus.ahb_write_req) begin
            if (occ + n_bytes <= DEPTH) store_tx    = 1'b1;
            else                        ahb_error_d = 1'b1;
          end
          if (bus.ahb_read_req)    ahb_error_d = 1'b1;
          if (bus.rx_packet_start) rx_nak_d    = 1'b1;
          if (bus.tx_send_req)     next_state  = TX_SEND;
        end
        TX_SEND: begin
          get_tx = bus.tx_byte_req && (occ != 7'd0);
          stall  = bus.ahb_write_req;
          if (bus.ahb_read_req)    ahb_error_d = 1'b1;
          if (bus.rx_packet_start) rx_nak_d    = 1'b1;
          if (bus.tx_packet_done) begin
            clear_d    = 1'b1;
            next_state = IDLE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      clear_q     <= 1'b0;
      ahb_error_q <= 1'b0;
      rx_nak_q    <= 1'b0;
      rx_error_q  <= 1'b0;
    end else begin
      state       <= next_state;
      clear_q     <= clear_d;
      ahb_error_q <= ahb_error_d;
      rx_nak_q    <= rx_nak_d;
      rx_error_q  <= rx_error_d;
    end
  end

  assign bus.store_rx_packet_data = store_rx;
  assign bus.get_rx_data          = get_rx;
  assign bus.store_tx_data        = store_tx;
  assign bus.get_tx_packet_data   = get_tx;
  assign bus.ahb_stall            = stall;
  assign bus.data_size            = bus.ahb_size;
  assign bus.clear                = clear_q;
  assign bus.ahb_error            = ahb_error_q;
  assign bus.rx_nak               = rx_nak_q;
  assign bus.rx_error             = rx_error_q;
  assign bus.buffer_reserved      = (state == TX_FILL) || (state == TX_SEND);
  assign bus.rx_data_ready        = (state == RX_READY);
  assign bus.tx_busy              = (state == TX_SEND);

endmodule

// File: tb/tb_buffer_controller.sv
// Directed self-checking bench for buffer_controller; occupancy is driven by hand
// to mimic the data buffer's count at each step.
module tb_buffer_controller;

`ifdef BUFFER_CONTROLLER_RX_TIMEOUT_EN
  localparam int TB_TIMEOUT = 10;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic tb_clk = 1'b0;
  logic n_rst  = 1'b0;
  int   tests  = 0;
  int   fails  = 0;
  int   strobe_count;

  always #5 tb_clk = ~tb_clk;

  buffer_controller_if bus ();

  buffer_controller #(.BUFFER_DEPTH(64), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk  (tb_clk),
    .n_rst(n_rst),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    bus.buffer_occupancy = 7'd0;
    bus.rx_packet_start  = 1'b0;
    bus.rx_byte_valid    = 1'b0;
    bus.rx_packet_done   = 1'b0;
    bus.rx_packet_error  = 1'b0;
    bus.ahb_read_req     = 1'b0;
    bus.ahb_write_req    = 1'b0;
    bus.ahb_size         = 2'd0;
    bus.tx_send_req      = 1'b0;
    bus.tx_byte_req      = 1'b0;
    bus.tx_packet_done   = 1'b0;
    bus.flush_req        = 1'b0;

    // Reset
    cyc(); cyc();
    check("rst_reserved", bus.buffer_reserved, 1'b0);
    check("rst_rx_ready", bus.rx_data_ready, 1'b0);
    check("rst_tx_busy",  bus.tx_busy, 1'b0);
    check("rst_pulses",   {bus.clear, bus.ahb_error, bus.rx_nak, bus.rx_error}, 4'b0);
    check("rst_strobes",  {bus.store_rx_packet_data, bus.get_rx_data, bus.store_tx_data,
                           bus.get_tx_packet_data, bus.ahb_stall}, 5'b0);
    n_rst = 1'b1;
    cyc();

    // RX packet of 4 bytes, then one 4-byte AHB read
    bus.rx_packet_start = 1'b1; cyc(); bus.rx_packet_start = 1'b0;
    strobe_count = 0;
    for (int i = 0; i < 4; i++) begin
      bus.buffer_occupancy = 7'(i); bus.rx_byte_valid = 1'b1; settle();
      strobe_count += int'(bus.store_rx_packet_data);
      cyc();
    end
    bus.rx_byte_valid = 1'b0;
    check("rx_store_count", strobe_count, 4);
    bus.buffer_occupancy = 7'd4; bus.rx_packet_done = 1'b1; cyc(); bus.rx_packet_done = 1'b0;
    check("rx_ready_set", bus.rx_data_ready, 1'b1);
    bus.ahb_read_req = 1'b1; bus.ahb_size = 2'd3; settle();
    check("rx_get", bus.get_rx_data, 1'b1);
    check("data_size", bus.data_size, 2'd3);
    cyc(); bus.ahb_read_req = 1'b0; bus.buffer_occupancy = 7'd0;
    check("rx_ready_clr", bus.rx_data_ready, 1'b0);
    check("rx_read_no_err", bus.ahb_error, 1'b0);

    // TX fill to 64 bytes, overfill, send 64 bytes
    strobe_count = 0;
    bus.ahb_write_req = 1'b1; bus.ahb_size = 2'd3;
    for (int i = 0; i < 16; i++) begin
      bus.buffer_occupancy = 7'(4 * i); settle();
      strobe_count += int'(bus.store_tx_data);
      cyc();
    end
    check("tx_store_count", strobe_count, 16);
    check("tx_reserved", bus.buffer_reserved, 1'b1);
    bus.buffer_occupancy = 7'd64; settle();
    check("tx_overfill_store", bus.store_tx_data, 1'b0);
    cyc(); bus.ahb_write_req = 1'b0;
    check("tx_overfill_err", bus.ahb_error, 1'b1);
    cyc();
    check("tx_err_pulse_end", bus.ahb_error, 1'b0);
    bus.tx_send_req = 1'b1; cyc(); bus.tx_send_req = 1'b0;
    check("tx_busy", bus.tx_busy, 1'b1);
    strobe_count = 0;
    bus.tx_byte_req = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.buffer_occupancy = 7'(64 - i); settle();
      strobe_count += int'(bus.get_tx_packet_data);
      cyc();
    end
    check("tx_get_count", strobe_count, 64);
    bus.buffer_occupancy = 7'd0; settle();
    check("tx_get_empty", bus.get_tx_packet_data, 1'b0);
    bus.ahb_write_req = 1'b1; settle();
    check("tx_send_stall", bus.ahb_stall, 1'b1);
    bus.ahb_write_req = 1'b0; bus.tx_byte_req = 1'b0;
    bus.tx_packet_done = 1'b1; cyc(); bus.tx_packet_done = 1'b0;
    check("tx_done_clear", bus.clear, 1'b1);
    check("tx_done_released", bus.buffer_reserved, 1'b0);
    cyc();
    check("tx_clear_pulse_end", bus.clear, 1'b0);

    // RX_READY with 2 bytes: short read error, NAK, then exact read
    bus.rx_packet_start = 1'b1; cyc(); bus.rx_packet_start = 1'b0;
    bus.buffer_occupancy = 7'd2; bus.rx_packet_done = 1'b1; cyc(); bus.rx_packet_done = 1'b0;
    bus.ahb_read_req = 1'b1; bus.ahb_size = 2'd3; settle();
    check("ready_short_get", bus.get_rx_data, 1'b0);
    cyc(); bus.ahb_read_req = 1'b0;
    check("ready_short_err", bus.ahb_error, 1'b1);
    bus.rx_packet_start = 1'b1; cyc(); bus.rx_packet_start = 1'b0;
    check("ready_nak", bus.rx_nak, 1'b1);
    check("ready_hold", bus.rx_data_ready, 1'b1);
    bus.ahb_read_req = 1'b1; bus.ahb_size = 2'd1; settle();
    check("ready_exact_get", bus.get_rx_data, 1'b1);
    cyc(); bus.ahb_read_req = 1'b0;
    check("ready_exact_idle", bus.rx_data_ready, 1'b0);
    check("ready_nak_end", bus.rx_nak, 1'b0);

    // Byte coincident with done on an empty buffer still counts as data
    bus.buffer_occupancy = 7'd0;
    bus.rx_packet_start = 1'b1; cyc(); bus.rx_packet_start = 1'b0;
    bus.rx_byte_valid = 1'b1; bus.rx_packet_done = 1'b1; settle();
    check("done_byte_store", bus.store_rx_packet_data, 1'b1);
    cyc(); bus.rx_byte_valid = 1'b0; bus.rx_packet_done = 1'b0;
    check("done_byte_ready", bus.rx_data_ready, 1'b1);
    bus.buffer_occupancy = 7'd1; bus.ahb_read_req = 1'b1; bus.ahb_size = 2'd0;
    cyc(); bus.ahb_read_req = 1'b0; bus.buffer_occupancy = 7'd0;
    check("done_byte_drained", bus.rx_data_ready, 1'b0);

    // Zero-length RX packet returns to IDLE
    bus.rx_packet_start = 1'b1; cyc(); bus.rx_packet_start = 1'b0;
    bus.rx_packet_done = 1'b1; cyc(); bus.rx_packet_done = 1'b0;
    check("zlp_not_ready", bus.rx_data_ready, 1'b0);
    bus.ahb_write_req = 1'b1; settle();
    check("zlp_idle_store", bus.store_tx_data, 1'b1);
    bus.ahb_write_req = 1'b0;

    // RX overflow at 64 bytes
    bus.rx_packet_start = 1'b1; cyc(); bus.rx_packet_start = 1'b0;
    bus.buffer_occupancy = 7'd64; bus.rx_byte_valid = 1'b1; settle();
    check("ovf_no_store", bus.store_rx_packet_data, 1'b0);
    cyc(); bus.rx_byte_valid = 1'b0; bus.buffer_occupancy = 7'd0;
    check("ovf_pulses", {bus.clear, bus.rx_error}, 2'b11);
    bus.ahb_write_req = 1'b1; settle();
    check("ovf_idle", {bus.store_tx_data, bus.ahb_stall}, 2'b10);
    bus.ahb_write_req = 1'b0;

    // RX start beats AHB write in IDLE; RX error aborts
    bus.rx_packet_start = 1'b1; bus.ahb_write_req = 1'b1; settle();
    check("race_stall", {bus.ahb_stall, bus.store_tx_data}, 2'b10);
    cyc(); bus.rx_packet_start = 1'b0;
    check("race_rx_active", bus.ahb_stall, 1'b1);
    bus.ahb_write_req = 1'b0;
    bus.rx_packet_error = 1'b1; cyc(); bus.rx_packet_error = 1'b0;
    check("rxerr_pulses", {bus.clear, bus.rx_error}, 2'b11);

    // Write + send in TX_FILL, then flush during TX_SEND
    bus.ahb_write_req = 1'b1; bus.ahb_size = 2'd0; cyc();
    bus.buffer_occupancy = 7'd1; bus.tx_send_req = 1'b1; settle();
    check("fill_send_store", bus.store_tx_data, 1'b1);
    cyc(); bus.ahb_write_req = 1'b0; bus.tx_send_req = 1'b0;
    check("fill_send_busy", bus.tx_busy, 1'b1);
    bus.flush_req = 1'b1; bus.tx_byte_req = 1'b1; bus.buffer_occupancy = 7'd2; settle();
    check("flush_gate", bus.get_tx_packet_data, 1'b0);
    cyc(); bus.flush_req = 1'b0; bus.tx_byte_req = 1'b0; bus.buffer_occupancy = 7'd0;
    check("flush_clear", bus.clear, 1'b1);
    check("flush_released", {bus.buffer_reserved, bus.tx_busy}, 2'b00);

    // RX watchdog
    bus.rx_packet_start = 1'b1; cyc(); bus.rx_packet_start = 1'b0;
`ifdef BUFFER_CONTROLLER_RX_TIMEOUT_EN
    repeat (9) cyc();
    check("wd_not_yet", bus.rx_error, 1'b0);
    cyc();
    check("wd_fired", {bus.clear, bus.rx_error}, 2'b11);
    bus.ahb_write_req = 1'b1; settle();
    check("wd_idle", {bus.store_tx_data, bus.ahb_stall}, 2'b10);
    bus.ahb_write_req = 1'b0;
`else
    repeat (300) cyc();
    check("wd_absent_err", bus.rx_error, 1'b0);
    bus.ahb_write_req = 1'b1; settle();
    check("wd_absent_active", {bus.ahb_stall, bus.store_tx_data}, 2'b10);
    bus.ahb_write_req = 1'b0;
    bus.flush_req = 1'b1; cyc(); bus.flush_req = 1'b0;
`endif

    // Reset mid-TX_FILL gives no clear pulse
    bus.ahb_write_req = 1'b1; cyc(); bus.ahb_write_req = 1'b0;
    n_rst = 1'b0; cyc();
    check("midrst_state", {bus.buffer_reserved, bus.clear}, 2'b00);
    n_rst = 1'b1; cyc();
    check("midrst_no_clear", bus.clear, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/buffer_controller.md
Name: buffer_controller

Overview:
- Sequencing and ownership controller for the 64-byte endpoint data buffer.
- Grants the buffer to one of three agents: USB RX packet writer, AHB slave (read or write), or USB TX packet reader.
- Gates all data_buffer strobes and generates its clear and buffer_reserved controls.
- Reports status, stall, NAK and error conditions to the AHB slave and the USB protocol logic.

Parameters:
- BUFFER_DEPTH, 64, buffer capacity in bytes; occupancy compares use 7-bit arithmetic.
- TIMEOUT_CYCLES, 255, RX inter-byte watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, synchronous active-low
- buffer_occupancy  in  7  occupancy from data_buffer
- rx_packet_start  in  1  USB RX began a DATA packet (1-cycle pulse)
- rx_byte_valid  in  1  USB RX has a byte ready on the buffer input
- rx_packet_done  in  1  USB RX packet ended with good CRC (pulse)
- rx_packet_error  in  1  USB RX packet aborted or bad CRC (pulse)
- ahb_read_req  in  1  AHB requests an RX data read
- ahb_write_req  in  1  AHB requests a TX data write
- ahb_size  in  2  transfer size minus 1 (0..3 means 1..4 bytes)
- tx_send_req  in  1  AHB command to transmit the filled buffer (pulse)
- tx_byte_req  in  1  USB TX wants the next byte
- tx_packet_done  in  1  USB TX finished the packet (pulse)
- flush_req  in  1  AHB forced flush (pulse)
- store_rx_packet_data  out  1  gated RX store strobe
- get_rx_data  out  1  gated AHB read strobe
- store_tx_data  out  1  gated AHB write strobe
- get_tx_packet_data  out  1  gated TX fetch strobe
- data_size  out  2  forwarded ahb_size
- clear  out  1  buffer flush pulse
- buffer_reserved  out  1  buffer owned by the TX path
- rx_data_ready  out  1  a received packet is waiting to be read
- tx_busy  out  1  in TX_SEND
- ahb_stall  out  1  AHB must hold its request (drives HREADY low)
- ahb_error  out  1  illegal AHB access (1-cycle pulse)
- rx_nak  out  1  RX packet refused; buffer busy (1-cycle pulse)
- rx_error  out  1  RX packet discarded (1-cycle pulse)

Behaviour:
- State register values: IDLE, RX_ACTIVE, RX_READY, TX_FILL, TX_SEND.
- Reset (n_rst=0 at a posedge): state=IDLE; all outputs 0.
- Strobes, ahb_stall, data_size: combinational from the current state and inputs, zero latency.
- clear, ahb_error, rx_nak, rx_error: registered 1-cycle pulses, asserted in the cycle after the cause.
- buffer_reserved = state in {TX_FILL, TX_SEND}. rx_data_ready = (state==RX_READY). tx_busy = (state==TX_SEND).
- Let n = ahb_size+1.
- flush_req (any state, highest priority): clear pulse; next state IDLE; all strobes forced to 0 that cycle.
- IDLE:
  - rx_packet_start -> RX_ACTIVE. It wins over a same-cycle ahb_write_req, which sees ahb_stall=1.
  - Otherwise ahb_write_req -> store_tx_data=1 and next state TX_FILL.
  - ahb_read_req -> ahb_error.
- RX_ACTIVE:
  - store_rx_packet_data = rx_byte_valid, only while occupancy < BUFFER_DEPTH.
  - rx_byte_valid at occupancy == BUFFER_DEPTH: overflow. No store; clear + rx_error; next state IDLE.
  - rx_packet_done -> RX_READY if occupancy > 0, else IDLE (zero-length packet).
  - rx_packet_error -> clear + rx_error; next state IDLE.
  - Any AHB request -> ahb_stall=1.
- RX_READY:
  - ahb_read_req with occupancy >= n -> get_rx_data=1.
  - If occupancy == n at that read -> IDLE.
  - ahb_read_req with occupancy < n -> ahb_error; no get.
  - rx_packet_start -> rx_nak; stay.
  - ahb_write_req -> ahb_error.
- TX_FILL:
  - ahb_write_req with occupancy+n <= BUFFER_DEPTH -> store_tx_data=1.
  - Write that would exceed BUFFER_DEPTH -> ahb_error; no store.
  - tx_send_req -> TX_SEND (empty buffer allowed: zero-length packet).
  - rx_packet_start -> rx_nak.
  - ahb_read_req -> ahb_error.
- TX_SEND:
  - get_tx_packet_data = tx_byte_req & (occupancy != 0). Requests on an empty buffer are ignored.
  - tx_packet_done -> clear pulse; next state IDLE.
  - ahb_write_req -> ahb_stall=1. ahb_read_req -> ahb_error.
  - rx_packet_start -> rx_nak.
- Simultaneous events:
  - tx_send_req together with ahb_write_req in TX_FILL: the store is performed, then the state moves.
  - rx_packet_done together with rx_byte_valid: the byte is stored; the next-state decision uses occupancy+1.
- Reset mid-operation: immediate IDLE; no clear pulse (data_buffer has its own reset).

Optional Feature:
- Macro: BUFFER_CONTROLLER_RX_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counter runs in RX_ACTIVE; it reloads to 0 on entry and on every rx_byte_valid.
  - Reaching TIMEOUT_CYCLES -> clear + rx_error; next state IDLE.
- Undefined: no counter is present; RX_ACTIVE waits indefinitely.

Test Plan:
- Reset, then rx_packet_start, 4x rx_byte_valid, rx_packet_done (occupancy 4) -> 4 store strobes; rx_data_ready=1; ahb_read_req size=3 -> get_rx_data=1; then IDLE with rx_data_ready=0.
- In IDLE: ahb_write_req size=3 x16 -> TX_FILL with buffer_reserved=1. A 17th write at occupancy 64 -> ahb_error, no store. tx_send_req, 64x tx_byte_req -> 64 gets; tx_packet_done -> clear pulse, IDLE.
- RX_READY (occupancy 2), ahb_read_req size=3 -> ahb_error=1, get_rx_data=0; rx_packet_start -> rx_nak=1; state unchanged.
- RX_ACTIVE at occupancy 64, rx_byte_valid -> no store; clear and rx_error 1 cycle later; IDLE.
- Same-cycle rx_packet_start + ahb_write_req in IDLE -> RX_ACTIVE; ahb_stall=1; store_tx_data=0. flush_req mid TX_SEND -> clear pulse; buffer_reserved=0 next cycle.
- With BUFFER_CONTROLLER_RX_TIMEOUT_EN and TIMEOUT_CYCLES=10: RX_ACTIVE with no bytes for 10 cycles -> rx_error and clear pulses; IDLE. Without the macro -> still in RX_ACTIVE after 300 cycles.
